// File: rtl/mastermind_scorer.sv
// mastermind_scorer
//   Scores one Mastermind guess against a secret code. A start pulse in IDLE
//   latches code and guess, then an exact-position (red) pass and a
//   colour-only (white) pass each walk one peg index per cycle. Used flags
//   make sure every code peg and every guess peg is consumed at most once,
//   so duplicate colours score correctly.
//
//   Optional feature: define MASTERMIND_EARLY_EXIT_EN to skip the white pass
//   when the red pass finds all pegs matching.
//
// Ports
//   clock  in   rising-edge system clock
//   reset  in   asynchronous active-high reset
//   start  in   scoring request, sampled only in IDLE
//   code   in   secret code, peg i at [i*COLOR_BITS +: COLOR_BITS]
//   guess  in   player guess, same packing as code
//   busy   out  high in every state except IDLE
//   done   out  one-cycle pulse; red/white/win valid in that cycle
//   red    out  exact-position match count
//   white  out  right-colour, wrong-position match count
//   win    out  red == NUM_PEGS, held until the next accepted start
module mastermind_scorer #(
   parameter  int NUM_PEGS   = 4,
   parameter  int COLOR_BITS = 3,
   localparam int CNT_W      = $clog2(NUM_PEGS + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_PEGS*COLOR_BITS-1:0] code,
   input  logic [NUM_PEGS*COLOR_BITS-1:0] guess,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_W-1:0]               red,
   output logic [CNT_W-1:0]               white,
   output logic                           win
);

   localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RED,
      ST_WHITE,
      ST_DONE
   } state_t;

   state_t state, state_n;

   logic [NUM_PEGS-1:0][COLOR_BITS-1:0] code_q, guess_q;
   logic [NUM_PEGS-1:0]                 code_used, guess_used;
   logic [IDX_W-1:0]                    idx;

   logic             last;
   logic             red_hit;
   logic [CNT_W-1:0] red_total;
   logic             found;
   logic [IDX_W-1:0] sel;
   logic             white_hit;

   assign last      = (idx == IDX_W'(NUM_PEGS - 1));
   assign red_hit   = (code_q[idx] == guess_q[idx]);
   // Red count including the current index; only meaningful in the red pass.
   assign red_total = red + CNT_W'(red_hit);

   // Lowest unused guess peg with the colour of the current code peg.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned j = 0; j < NUM_PEGS; j++) begin
         if (!found && !guess_used[j] && (guess_q[j] == code_q[idx])) begin
            found = 1'b1;
            sel   = IDX_W'(j);
         end
      end
   end

   assign white_hit = !code_used[idx] && found;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = (state != ST_IDLE);
      done    = (state == ST_DONE);
      case (state)
         ST_IDLE:  if (start) state_n = ST_RED;
         ST_RED: begin
            if (last) begin
`ifdef MASTERMIND_EARLY_EXIT_EN
               if (red_total == CNT_W'(NUM_PEGS)) state_n = ST_DONE;
               else                               state_n = ST_WHITE;
`else
               state_n = ST_WHITE;
`endif
            end
         end
         ST_WHITE: if (last) state_n = ST_DONE;
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         code_q     <= '0;
         guess_q    <= '0;
         code_used  <= '0;
         guess_used <= '0;
         idx        <= '0;
         red        <= '0;
         white      <= '0;
         win        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  code_q     <= code;
                  guess_q    <= guess;
                  code_used  <= '0;
                  guess_used <= '0;
                  idx        <= '0;
                  red        <= '0;
                  white      <= '0;
                  win        <= 1'b0;
               end
            end
            ST_RED: begin
               if (red_hit) begin
                  code_used[idx]  <= 1'b1;
                  guess_used[idx] <= 1'b1;
                  red             <= red_total;
               end
               idx <= last ? '0 : idx + 1'b1;
`ifdef MASTERMIND_EARLY_EXIT_EN
               // win must already be valid in the DONE cycle when white is skipped.
               if (last && (red_total == CNT_W'(NUM_PEGS))) win <= 1'b1;
`endif
            end
            ST_WHITE: begin
               if (white_hit) begin
                  code_used[idx]  <= 1'b1;
                  guess_used[sel] <= 1'b1;
                  white           <= white + 1'b1;
               end
               idx <= last ? '0 : idx + 1'b1;
               if (last) win <= (red == CNT_W'(NUM_PEGS));
            end
            default: ;
         endcase
      end
   end

endmodule
